div_unit: RTL and testbench

Multi-cycle iterative divider for the EX stage. It consumes the operand pair (Read1 as dividend, Read2 as divisor) and the divide control latched by the ID/EX pipeline register. It raises Busy so hazard logic stalls IF/ID/ID_EX while it runs. It returns quotient and remainder for the HI/LO write path (quotient to LO, remainder to HI) with a one-cycle Done strobe.

---
 rtl/div_unit_if.sv | 26 ++
 rtl/div_unit.sv | 128 ++++++++++++
 tb/tb_div_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/result bundle between the ID/EX operand path and the iterative divider.
// Handshake: Start is a one-edge request honoured only while Busy=0 and Done=0; Done is a one-cycle result strobe.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             Abort;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivByZero;

  modport master (
    output Start, Signed, Dividend, Divisor, Abort,
    input  Busy, Done, Quotient, Remainder, DivByZero
  );

  modport slave (
    input  Start, Signed, Dividend, Divisor, Abort,
    output Busy, Done, Quotient, Remainder, DivByZero
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider (div/divu) for the EX stage: one quotient bit per cycle,
// sign-fixed quotient/remainder registered for the HI/LO write path.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic        Clk,
  input  logic        Reset_n,
  div_unit_if.slave   bus,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic             q_neg_q, r_neg_q, dbz_q;
  logic             busy_q, done_q, dbz_out_q;
  logic [WIDTH-1:0] quot_out_q, rem_out_q;

  // Restoring step: shifted remainder is WIDTH+1 bits, the top bit of the
  // subtraction result is the borrow that decides keep/restore.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, quo_fix, rem_fix;

  logic             sign_a, sign_b, div_zero_in;

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, div_q};
    fits    = ~trial[WIDTH+1];
    rem_nxt = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], fits};
    quo_fix = (q_neg_q && !dbz_q) ? (~quo_nxt + ONE) : quo_nxt;
    rem_fix = (r_neg_q && !dbz_q) ? (~rem_nxt + ONE) : rem_nxt;
  end

  assign sign_a      = bus.Signed & bus.Dividend[WIDTH-1];
  assign sign_b      = bus.Signed & bus.Divisor[WIDTH-1];
  assign div_zero_in = (bus.Divisor == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.Start && !bus.Abort) state_d = CALC;
      CALC: begin
        if (bus.Abort)            state_d = IDLE;
        else if (count_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  // A zero divisor keeps the raw dividend so the all-ones walk leaves it in rem untouched.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      count_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dbz_q      <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dbz_out_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Start && !bus.Abort) begin
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= (sign_a && !div_zero_in) ? (~bus.Dividend + ONE) : bus.Dividend;
            div_q   <= sign_b ? (~bus.Divisor + ONE) : bus.Divisor;
            q_neg_q <= sign_a ^ sign_b;
            r_neg_q <= sign_a;
            dbz_q   <= div_zero_in;
          end
        end
        CALC: begin
          if (!bus.Abort) begin
            rem_q   <= rem_nxt;
            quo_q   <= quo_nxt;
            count_q <= count_q + CNT_ONE;
            if (count_q == LAST) begin
              quot_out_q <= quo_fix;
              rem_out_q  <= rem_fix;
              dbz_out_q  <= dbz_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Quotient  = quot_out_q;
  assign bus.Remainder = rem_out_q;
  assign bus.DivByZero = dbz_out_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: unsigned/signed results, divide-by-zero, overflow,
// ignored Start pulses, abort and mid-run reset.
module tb_div_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         failures = 0;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .Clk       (clk),
    .Reset_n   (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.Start    = 1'b1;
    bus.Dividend = a;
    bus.Divisor  = b;
    bus.Signed   = s;
    step();
    bus.Start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp_q,
                           input logic [31:0] exp_r, input logic exp_z);
    int  lat;
    int  busy_cnt;
    logic seen;
    lat = 0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Busy) busy_cnt++;
      if (bus.Done) begin
        seen = 1'b1;
        break;
      end
      step();
      lat++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd32);
    check({tag, "_quotient"}, bus.Quotient, exp_q);
    check({tag, "_remainder"}, bus.Remainder, exp_r);
    check({tag, "_divbyzero"}, 32'(bus.DivByZero), 32'(exp_z));
    step();
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    check({tag, "_busy_after"}, 32'(bus.Busy), 32'd0);
    check({tag, "_done_after"}, 32'(bus.Done), 32'd0);
  endtask

  initial begin
    int seen_at;
    int done_cnt;

    bus.Start    = 1'b0;
    bus.Signed   = 1'b0;
    bus.Dividend = '0;
    bus.Divisor  = '0;
    bus.Abort    = 1'b0;
    rst_n        = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_quotient", bus.Quotient, 32'd0);
    check("rst_remainder", bus.Remainder, 32'd0);
    check("rst_divbyzero", 32'(bus.DivByZero), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    start_pulse(32'd100, 32'd7, 1'b0);
    wait_done("divu_100_7", 32'd14, 32'd2, 1'b0);

    start_pulse(32'hFFFF_FF9C, 32'd7, 1'b1);
    wait_done("div_m100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

    start_pulse(32'd100, 32'hFFFF_FFF9, 1'b1);
    wait_done("div_100_m7", 32'hFFFF_FFF2, 32'd2, 1'b0);

    start_pulse(32'h1234_5678, 32'd0, 1'b0);
    wait_done("div_by_zero", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);

    start_pulse(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("overflow", 32'h8000_0000, 32'd0, 1'b0);

    // Starts at +5, +20 (CALC) and +33 (DONE) must all be dropped.
    start_pulse(32'd1000, 32'd33, 1'b0);
    seen_at = -1;
    for (int i = 1; i <= 33; i++) begin
      if (i == 5 || i == 20 || i == 33) begin
        bus.Start    = 1'b1;
        bus.Dividend = 32'h0000_FFFF;
        bus.Divisor  = 32'd3;
      end
      step();
      bus.Start = 1'b0;
      if (bus.Done && seen_at < 0) seen_at = i;
      if (i == 32) begin
        check("ign_quotient", bus.Quotient, 32'd30);
        check("ign_remainder", bus.Remainder, 32'd10);
      end
    end
    check("ign_done_at", 32'(seen_at), 32'd32);
    check("ign_busy_after", 32'(bus.Busy), 32'd0);
    check("ign_quotient_held", bus.Quotient, 32'd30);
    start_pulse(32'hDEAD_BEEF, 32'd16, 1'b0);
    wait_done("second", 32'h0DEA_DBEE, 32'h0000_000F, 1'b0);

    start_pulse(32'd50, 32'd5, 1'b0);
    for (int i = 1; i <= 9; i++) step();
    bus.Abort = 1'b1;
    step();
    bus.Abort = 1'b0;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    check("abort_quotient_held", bus.Quotient, 32'h0DEA_DBEE);
    check("abort_remainder_held", bus.Remainder, 32'h0000_000F);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done) done_cnt++;
      step();
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);

    bus.Start    = 1'b1;
    bus.Abort    = 1'b1;
    bus.Dividend = 32'd9;
    bus.Divisor  = 32'd3;
    step();
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    check("abort_start_busy", 32'(bus.Busy), 32'd0);
    check("abort_start_state", 32'(state_dbg), 32'd0);

    start_pulse(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_busy", 32'(bus.Busy), 32'd0);
    check("midrst_done", 32'(bus.Done), 32'd0);
    check("midrst_quotient", bus.Quotient, 32'd0);
    check("midrst_remainder", bus.Remainder, 32'd0);
    check("midrst_divbyzero", 32'(bus.DivByZero), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);

    start_pulse(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
    wait_done("div_m7_m2", 32'd3, 32'hFFFF_FFFF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
